ram_dp: RTL and testbench



---
 rtl/ram_dp_pkg.sv | 18 +
 rtl/ram_dp_if.sv | 35 +++
 rtl/ram_dp.sv | 63 ++++++
 tb/tb_ram_dp.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_pkg.sv
// Shared types and defaults for the simple dual-port RAM.
// The read-port action enum names the three things rddata can do on an edge.
package ram_dp_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;
    localparam int unsigned DEFAULT_SIZE  = 1024;

    typedef enum logic [1:0] {
        RD_HOLD,
        RD_LOAD,
        RD_ZERO
    } rd_action_e;

    function automatic int unsigned addr_bits(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/ram_dp_if.sv
// Read/write port bundle for ram_dp; the master drives addresses and data,
// the slave (the RAM) returns registered read data.
interface ram_dp_if
    import ram_dp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned ABITS = addr_bits(DEFAULT_SIZE)
) ();

    logic             rden;
    logic [ABITS-1:0] rdaddr;
    logic [WIDTH-1:0] rddata;
    logic             wren;
    logic [ABITS-1:0] wraddr;
    logic [WIDTH-1:0] wrdata;

    modport master (
        output rden,
        output rdaddr,
        input  rddata,
        output wren,
        output wraddr,
        output wrdata
    );

    modport slave (
        input  rden,
        input  rdaddr,
        output rddata,
        input  wren,
        input  wraddr,
        input  wrdata
    );

endinterface

// File: rtl/ram_dp.sv
// Single-clock simple dual-port RAM with a registered read port.
// Same-address read+write performs the write and holds rddata.
module ram_dp
    import ram_dp_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned SIZE  = DEFAULT_SIZE
) (
    input  logic     clk,
    input  logic     rst,
    ram_dp_if.slave  bus
);

    localparam int unsigned      ABITS  = $clog2(SIZE);
    localparam logic [ABITS:0]   SIZE_L = (ABITS + 1)'(SIZE);

    logic [WIDTH-1:0] mem [SIZE];
    logic [WIDTH-1:0] rddata_q;

    logic       wr_in_range;
    logic       rd_in_range;
    logic       collision;
    logic       wr_en;
    rd_action_e rd_action;

    // Extra top bit keeps the compare correct when SIZE is a power of two.
    assign wr_in_range = ({1'b0, bus.wraddr} < SIZE_L);
    assign rd_in_range = ({1'b0, bus.rdaddr} < SIZE_L);
    assign collision   = bus.rden && bus.wren && wr_in_range
                       && (bus.rdaddr == bus.wraddr);

    // Gating with rst drops any write whose edge sees reset asserted.
    assign wr_en = bus.wren && wr_in_range && !rst;

    always_comb begin
        rd_action = RD_HOLD;
        if (bus.rden && !collision) begin
            rd_action = rd_in_range ? RD_LOAD : RD_ZERO;
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; only rddata is reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[bus.wraddr] <= bus.wrdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rddata_q <= '0;
        end else begin
            case (rd_action)
                RD_LOAD: rddata_q <= mem[bus.rdaddr];
                RD_ZERO: rddata_q <= '0;
                default: rddata_q <= rddata_q;
            endcase
        end
    end

    assign bus.rddata = rddata_q;

endmodule

// File: tb/tb_ram_dp.sv
// Self-checking bench for ram_dp (SIZE=12 so addresses 12..15 are out of range),
// compared against an array model of the storage and read register.
module tb_ram_dp;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SIZE  = 12;
    localparam int unsigned ABITS = 4;

    logic clk;
    logic rst;

    ram_dp_if #(.WIDTH(WIDTH), .ABITS(ABITS)) bus ();

    ram_dp #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] model [SIZE];
    logic [WIDTH-1:0] exp_rd;
    int               n_checks;
    int               n_fail;

    task automatic set_in(input logic rden, input int rdaddr,
                          input logic wren, input int wraddr,
                          input logic [WIDTH-1:0] wrdata);
        bus.rden   = rden;
        bus.rdaddr = ABITS'(rdaddr);
        bus.wren   = wren;
        bus.wraddr = ABITS'(wraddr);
        bus.wrdata = wrdata;
    endtask

    // One clock edge: apply the storage rules to the model, then settle 1 time unit.
    task automatic step();
        int ra;
        int wa;
        @(posedge clk);
        ra = int'(bus.rdaddr);
        wa = int'(bus.wraddr);
        if (rst) begin
            exp_rd = '0;
        end else begin
            if (bus.rden) begin
                if (bus.wren && ra == wa && ra < SIZE) begin
                    exp_rd = exp_rd;
                end else if (ra < SIZE) begin
                    exp_rd = model[ra];
                end else begin
                    exp_rd = '0;
                end
            end
            if (bus.wren && wa < SIZE) model[wa] = bus.wrdata;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b0, 0, 1'b0, 0, '0);
        exp_rd = '0;
        for (int i = 0; i < SIZE; i++) model[i] = '0;
        #1;
        n_checks++;
        if (bus.rddata !== exp_rd) begin
            n_fail++;
            $display("FAIL reset_initial: rddata=%h expected %h", bus.rddata, exp_rd);
        end
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            set_in(1'b0, 0, 1'b1, i, WIDTH'(16'h0100 + i * 16'h0111));
            step();
        end
        set_in(1'b1, 1, 1'b0, 0, '0);
        step();
        n_checks++;
        if (bus.rddata !== exp_rd) begin
            n_fail++;
            $display("FAIL reset_preload: rddata=%h expected %h", bus.rddata, exp_rd);
        end
        // Assert reset mid-cycle: rddata must clear before the next edge.
        #3;
        rst = 1'b1;
        exp_rd = '0;
        #1;
        n_checks++;
        if (bus.rddata !== exp_rd) begin
            n_fail++;
            $display("FAIL reset_async: rddata=%h expected %h", bus.rddata, exp_rd);
        end
        set_in(1'b1, 1, 1'b1, 2, 16'hDEAD);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.rddata !== exp_rd) begin
                n_fail++;
                $display("FAIL reset_held: rddata=%h expected %h", bus.rddata, exp_rd);
            end
        end
        rst = 1'b0;
        set_in(1'b1, 2, 1'b0, 0, '0);
        step();
        n_checks++;
        if (bus.rddata !== exp_rd) begin
            n_fail++;
            $display("FAIL reset_mem_untouched: rddata=%h expected %h", bus.rddata, exp_rd);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 16; i++) begin
            set_in(1'b0, 0, 1'b1, i, WIDTH'(i + 1));
            step();
        end
        for (int i = 0; i < 16; i++) begin
            set_in(1'b1, i, 1'b0, 0, '0);
            step();
            n_checks++;
            if (bus.rddata !== exp_rd) begin
                n_fail++;
                $display("FAIL write_read addr %0d: rddata=%h expected %h", i, bus.rddata, exp_rd);
            end
        end
    endtask

    task automatic test_hold();
        set_in(1'b1, 3, 1'b0, 0, '0);
        step();
        n_checks++;
        if (bus.rddata !== 16'h0004) begin
            n_fail++;
            $display("FAIL hold_first_read: rddata=%h expected %h", bus.rddata, 16'h0004);
        end
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 3, 1'b1, 3, 16'h00AA);
            step();
            n_checks++;
            if (bus.rddata !== 16'h0004) begin
                n_fail++;
                $display("FAIL hold_idle cycle %0d: rddata=%h expected %h", i, bus.rddata, 16'h0004);
            end
        end
        set_in(1'b1, 3, 1'b0, 0, '0);
        step();
        n_checks++;
        if (bus.rddata !== 16'h00AA) begin
            n_fail++;
            $display("FAIL hold_reread: rddata=%h expected %h", bus.rddata, 16'h00AA);
        end
    endtask

    task automatic test_collision();
        set_in(1'b1, 6, 1'b0, 0, '0);
        step();
        n_checks++;
        if (bus.rddata !== 16'h0007) begin
            n_fail++;
            $display("FAIL collision_setup: rddata=%h expected %h", bus.rddata, 16'h0007);
        end
        set_in(1'b1, 5, 1'b1, 5, 16'h0055);
        step();
        n_checks++;
        if (bus.rddata !== 16'h0007) begin
            n_fail++;
            $display("FAIL collision_hold: rddata=%h expected %h", bus.rddata, 16'h0007);
        end
        set_in(1'b1, 5, 1'b0, 0, '0);
        step();
        n_checks++;
        if (bus.rddata !== 16'h0055) begin
            n_fail++;
            $display("FAIL collision_written: rddata=%h expected %h", bus.rddata, 16'h0055);
        end
    endtask

    task automatic test_bounds();
        set_in(1'b0, 0, 1'b1, 15, 16'h0099);
        step();
        for (int i = 0; i < SIZE; i++) begin
            set_in(1'b1, i, 1'b0, 0, '0);
            step();
            n_checks++;
            if (bus.rddata !== exp_rd || bus.rddata === 16'h0099) begin
                n_fail++;
                $display("FAIL bounds_unchanged addr %0d: rddata=%h expected %h", i, bus.rddata, exp_rd);
            end
        end
        set_in(1'b1, 13, 1'b0, 0, '0);
        step();
        n_checks++;
        if (bus.rddata !== '0) begin
            n_fail++;
            $display("FAIL bounds_read_oob: rddata=%h expected %h", bus.rddata, 16'h0000);
        end
        set_in(1'b0, 0, 1'b1, 11, 16'hBEEF);
        step();
        set_in(1'b1, 11, 1'b0, 0, '0);
        step();
        n_checks++;
        if (bus.rddata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL bounds_last_word: rddata=%h expected %h", bus.rddata, 16'hBEEF);
        end
    endtask

    task automatic test_reset_traffic();
        for (int i = 0; i < 8; i++) begin
            set_in(1'b0, 0, 1'b1, i, WIDTH'(16'h5000 + i));
            if (i == 4) begin
                #3;
                rst = 1'b1;
                exp_rd = '0;
            end
            step();
            if (i == 4) begin
                n_checks++;
                if (bus.rddata !== '0) begin
                    n_fail++;
                    $display("FAIL traffic_reset: rddata=%h expected %h", bus.rddata, 16'h0000);
                end
                rst = 1'b0;
                break;
            end
        end
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, i, 1'b0, 0, '0);
            step();
            n_checks++;
            if (bus.rddata !== exp_rd) begin
                n_fail++;
                $display("FAIL traffic_persist addr %0d: rddata=%h expected %h", i, bus.rddata, exp_rd);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            set_in(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                   WIDTH'($urandom));
            step();
            n_checks++;
            if (bus.rddata !== exp_rd) begin
                n_fail++;
                $display("FAIL random cycle %0d: rddata=%h expected %h", n, bus.rddata, exp_rd);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_hold();
        test_collision();
        test_bounds();
        test_reset_traffic();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
